// File: rtl/pause_key_ctrl_pkg.sv
// Shared constants and helpers for the pause key controller.
// FSM encodings are plain localparams so older blocks can reuse them directly.
package pause_key_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_PRESSED = 2'd1;
    localparam state_t ST_HELD    = 2'd2;

    // Converts a time in ms into clk cycles, with a floor of 2 cycles.
    function automatic int ms_to_cycles(input int clk_hz, input int ms);
        int cyc;
        cyc = (clk_hz / 1000) * ms;
        return (cyc < 2) ? 2 : cyc;
    endfunction

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int width_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pause_key_ctrl_if.sv
// Key-side bundle: raw pin in, debounced level and strobes out.
interface pause_key_ctrl_if;
    logic key_in;
    logic key_stable;
    logic press_pulse;
    logic pause_state;
    logic clr_pulse;

    modport master (
        output key_in,
        input  key_stable, press_pulse, pause_state, clr_pulse
    );

    modport slave (
        input  key_in,
        output key_stable, press_pulse, pause_state, clr_pulse
    );
endinterface

// File: rtl/pause_key_ctrl_debounce.sv
// Two-flop synchronizer, polarity normalisation and debounce filter.
// key_stable is 1 while pressed and flips only after DB_CYC consecutive differing samples.
module key_debounce
    import pause_key_pkg::*;
#(
    parameter int DB_CYC         = 4,
    parameter bit KEY_ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic key_stable
);
    localparam int   CNT_W    = width_of(DB_CYC);
    localparam logic RAW_IDLE = KEY_ACTIVE_LOW;

    logic             sync1_q, sync2_q;
    logic             key_sync;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= RAW_IDLE;
            sync2_q  <= RAW_IDLE;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= key_in;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign key_sync = sync2_q ^ RAW_IDLE;

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (key_sync != stable_q) begin
            if (cnt_q == CNT_W'(DB_CYC - 1)) begin
                stable_d = key_sync;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign key_stable = stable_q;

endmodule

// File: rtl/pause_key_ctrl.sv
// Push-button to pause toggle: debounce, press FSM, press strobe, pause flag.
// Define PAUSE_KEY_LONG_CLR_EN to add long-press detection with a clr_pulse strobe.
module pause_key_ctrl
    import pause_key_pkg::*;
#(
    parameter int CLK_HZ         = 50_000_000,
    parameter int DEBOUNCE_MS    = 20,
    parameter int LONG_MS        = 1000,
    parameter bit KEY_ACTIVE_LOW = 1'b1,
    parameter bit PAUSE_INIT     = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    pause_key_ctrl_if.slave  bus
);
    localparam int DB_CYC   = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
    localparam int LONG_CYC = (CLK_HZ / 1000) * LONG_MS;

    logic   key_stable;
    state_t state_q, state_d;
    logic   press_q, press_d;
    logic   pause_q, pause_d;
    logic   clr_q, clr_d;

    key_debounce #(
        .DB_CYC         (DB_CYC),
        .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW)
    ) u_debounce (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_in     (bus.key_in),
        .key_stable (key_stable)
    );

`ifdef PAUSE_KEY_LONG_CLR_EN
    localparam int HOLD_W = width_of(LONG_CYC + 1);
    logic [HOLD_W-1:0] hold_q, hold_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hold_q <= '0;
        else        hold_q <= hold_d;
    end
`else
    logic unused_long_cyc;
    assign unused_long_cyc = (LONG_CYC > 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            press_q <= 1'b0;
            pause_q <= PAUSE_INIT;
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            press_q <= press_d;
            pause_q <= pause_d;
            clr_q   <= clr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        press_d = 1'b0;
        pause_d = pause_q;
        clr_d   = 1'b0;
`ifdef PAUSE_KEY_LONG_CLR_EN
        hold_d  = hold_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (key_stable) begin
                    state_d = ST_PRESSED;
                    press_d = 1'b1;
                    pause_d = ~pause_q;
`ifdef PAUSE_KEY_LONG_CLR_EN
                    hold_d  = '0;
`endif
                end
            end
            ST_PRESSED: begin
                if (!key_stable) begin
                    state_d = ST_IDLE;
`ifdef PAUSE_KEY_LONG_CLR_EN
                end else if (hold_q == HOLD_W'(LONG_CYC - 1)) begin
                    // Long press forces the display paused and freezes the hold count.
                    state_d = ST_HELD;
                    clr_d   = 1'b1;
                    pause_d = 1'b1;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
`endif
                end
            end
`ifdef PAUSE_KEY_LONG_CLR_EN
            ST_HELD: begin
                if (!key_stable) state_d = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.key_stable  = key_stable;
    assign bus.press_pulse = press_q;
    assign bus.pause_state = pause_q;
    assign bus.clr_pulse   = clr_q;

endmodule

// File: tb/tb_pause_key_ctrl.sv
// Scoreboard bench for pause_key_ctrl: a timing model of the key filter predicts
// key_stable and pulse events; an independent monitor compares them to the DUT.
module tb_pause_key_ctrl;

    localparam int CLK_HZ      = 1000;
    localparam int DEBOUNCE_MS = 4;
    localparam int LONG_MS     = 20;
    localparam int DB_CYC      = 4;
    localparam int LONG_CYC    = 20;
    localparam bit PAUSE_INIT  = 1'b1;

    typedef struct {
        int cyc;
        bit val;
    } stable_ev_t;

    typedef struct {
        int cyc;
        bit is_clr;
        bit pause;
    } pulse_ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    stable_ev_t stq[$];
    pulse_ev_t  evq[$];
    bit         hist[$];
    bit         m_stable;
    bit         m_pause;
    int         long_due;

    pause_key_ctrl_if bus();

    pause_key_ctrl #(
        .CLK_HZ         (CLK_HZ),
        .DEBOUNCE_MS    (DEBOUNCE_MS),
        .LONG_MS        (LONG_MS),
        .KEY_ACTIVE_LOW (1'b1),
        .PAUSE_INIT     (PAUSE_INIT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model. The pressed level driven after edge k reaches the filter at
    // edge k+3; the filter flips once its last DB_CYC samples all disagree with it.
    task automatic step(input int k, input bit pressed);
        int m;
        bit all_diff;
        hist.push_back(pressed);
        m = k + 3;
        all_diff = 1'b1;
        for (int i = 0; i < DB_CYC; i++)
            if (hist[hist.size() - 1 - i] == m_stable) all_diff = 1'b0;
        if (all_diff) begin
            m_stable = ~m_stable;
            if (m_stable) begin
                m_pause = ~m_pause;
                evq.push_back('{m + 1, 1'b0, m_pause});
                long_due = m + 1 + LONG_CYC;
            end else begin
                long_due = -1;
            end
        end
        stq.push_back('{m, m_stable});
`ifdef PAUSE_KEY_LONG_CLR_EN
        if (long_due >= 0 && m == long_due - 1 && m_stable) begin
            m_pause = 1'b1;
            evq.push_back('{long_due, 1'b1, 1'b1});
            long_due = -1;
        end
`endif
    endtask

    task automatic drive(input bit pressed, input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            bus.key_in = ~pressed;
            step(cyc, pressed);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_key_stable"}, bus.key_stable, 0);
        check({tag, "_press_pulse"}, bus.press_pulse, 0);
        check({tag, "_clr_pulse"}, bus.clr_pulse, 0);
        check({tag, "_pause_state"}, bus.pause_state, PAUSE_INIT);
    endtask

    task automatic do_reset(input bit pressed);
        @(posedge clk);
        #1;
        bus.key_in = ~pressed;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("in_reset");
        repeat (3) @(posedge clk);
        stq.delete();
        evq.delete();
        hist.delete();
        m_stable = 1'b0;
        m_pause  = PAUSE_INIT;
        long_due = -1;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check_reset_outputs("after_reset");
        repeat (DB_CYC + 2) hist.push_back(1'b0);
        step(cyc, pressed);
    endtask

    task automatic idle_and_check_pause(input string name);
        drive(1'b0, 14);
        check(name, bus.pause_state, m_pause);
    endtask

    // Monitor: pops expectations as the DUT presents key_stable samples and pulses.
    always @(negedge clk) begin
        if (rst_n) begin
            while (stq.size() > 0 && stq[0].cyc < cyc) void'(stq.pop_front());
            if (stq.size() > 0 && stq[0].cyc == cyc) begin
                check("key_stable", bus.key_stable, stq[0].val);
                void'(stq.pop_front());
            end
            if (bus.press_pulse || bus.clr_pulse) begin
                if (evq.size() == 0) begin
                    check("pulse_unexpected", {bus.press_pulse, bus.clr_pulse}, 0);
                end else begin
                    pulse_ev_t e;
                    e = evq.pop_front();
                    check("pulse_cycle", cyc, e.cyc);
                    check("pulse_kind", {bus.press_pulse, bus.clr_pulse}, e.is_clr ? 2'b01 : 2'b10);
                    check("pause_at_pulse", bus.pause_state, e.pause);
                end
            end else if (evq.size() > 0 && evq[0].cyc < cyc) begin
                check("pulse_missed", cyc, evq[0].cyc);
                void'(evq.pop_front());
            end
        end
    end

    initial begin
        bus.key_in = 1'b1;
        do_reset(1'b0);

        // Clean press then release
        drive(1'b0, 4);
        drive(1'b1, 10);
        idle_and_check_pause("pause_after_clean_press");

        // Bounce: alternating runs of 1..3 cycles never settle
        begin
            bit lvl;
            int total;
            lvl = 1'b1;
            total = 0;
            while (total < 30) begin
                int n;
                n = $urandom_range(1, 3);
                drive(lvl, n);
                total += n;
                lvl = ~lvl;
            end
        end
        idle_and_check_pause("pause_after_bounce");

        // Double press
        drive(1'b1, 10);
        drive(1'b0, 10);
        drive(1'b1, 10);
        idle_and_check_pause("pause_after_double_press");

        // Long press
        drive(1'b1, 40);
        idle_and_check_pause("pause_after_long_press");

        // Random runs of 1..8 cycles
        begin
            bit lvl;
            int total;
            lvl = 1'b0;
            total = 0;
            while (total < 200) begin
                int n;
                n = $urandom_range(1, 8);
                drive(lvl, n);
                total += n;
                lvl = ~lvl;
            end
        end
        idle_and_check_pause("pause_after_random");

        // Reset while pressed, key still held afterwards
        drive(1'b1, 10);
        do_reset(1'b1);
        drive(1'b1, 10);
        idle_and_check_pause("pause_after_reset_press");

        check("pending_pulses", evq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
